// File: rtl/zeroriscy_alu_arbiter.sv
// Two-port arbiter sharing the combinational zero-riscy ALU, with a 1-entry response buffer per port.
// Optional macro ZERORISCY_ALU_ARB_RR_EN selects round-robin instead of fixed priority with starvation counter.
module zeroriscy_alu_arbiter #(
    parameter int STARVE_MAX   = 4,
    parameter int CNT_W        = 4,
    parameter int ALU_OP_WIDTH = 6,
    parameter int DATA_W       = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    req0_valid_i,
    output logic                    req0_ready_o,
    input  logic [ALU_OP_WIDTH-1:0] req0_operator_i,
    input  logic [DATA_W-1:0]       req0_operand_a_i,
    input  logic [DATA_W-1:0]       req0_operand_b_i,
    input  logic                    req1_valid_i,
    output logic                    req1_ready_o,
    input  logic [ALU_OP_WIDTH-1:0] req1_operator_i,
    input  logic [DATA_W-1:0]       req1_operand_a_i,
    input  logic [DATA_W-1:0]       req1_operand_b_i,
    output logic                    rsp0_valid_o,
    input  logic                    rsp0_ready_i,
    output logic [DATA_W-1:0]       rsp0_result_o,
    output logic                    rsp0_cmp_o,
    output logic                    rsp1_valid_o,
    input  logic                    rsp1_ready_i,
    output logic [DATA_W-1:0]       rsp1_result_o,
    output logic                    rsp1_cmp_o,
    output logic [ALU_OP_WIDTH-1:0] alu_operator_o,
    output logic [DATA_W-1:0]       alu_operand_a_o,
    output logic [DATA_W-1:0]       alu_operand_b_o,
    input  logic [DATA_W-1:0]       alu_result_i,
    input  logic                    alu_cmp_i,
    output logic [1:0]              grant_o
);

    localparam logic [ALU_OP_WIDTH-1:0] ALU_ADD = ALU_OP_WIDTH'(6'b011000);

    logic              elig0, elig1;
    logic              vld0_p1, vld1_p1;
    logic [DATA_W-1:0] res0_p1, res1_p1;
    logic              cmp0_p1, cmp1_p1;

    // A buffer being drained this cycle counts as free, so it can be refilled on the same edge.
    assign elig0 = req0_valid_i && (!vld0_p1 || rsp0_ready_i);
    assign elig1 = req1_valid_i && (!vld1_p1 || rsp1_ready_i);

`ifdef ZERORISCY_ALU_ARB_RR_EN
    logic last_grant_p1;  // 1 = port 1 was granted last

    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant_p1 <= 1'b1;
        end else if (grant_o[0]) begin
            last_grant_p1 <= 1'b0;
        end else if (grant_o[1]) begin
            last_grant_p1 <= 1'b1;
        end
    end

    always_comb begin
        grant_o = 2'b00;
        if (!rst) begin
            if (elig0 && elig1) begin
                grant_o = last_grant_p1 ? 2'b01 : 2'b10;
            end else if (elig0) begin
                grant_o = 2'b01;
            end else if (elig1) begin
                grant_o = 2'b10;
            end
        end
    end
`else
    logic [CNT_W-1:0] starve_cnt_p1;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] val);
        if (val >= CNT_W'(STARVE_MAX)) begin
            return CNT_W'(STARVE_MAX);
        end
        return val + CNT_W'(1);
    endfunction

    // Counts port-0 wins over an eligible port 1; any other cycle resets the run.
    always_ff @(posedge clk) begin
        if (rst) begin
            starve_cnt_p1 <= '0;
        end else if (grant_o[0] && elig1) begin
            starve_cnt_p1 <= sat_inc(starve_cnt_p1);
        end else begin
            starve_cnt_p1 <= '0;
        end
    end

    always_comb begin
        grant_o = 2'b00;
        if (!rst) begin
            if (elig0 && elig1) begin
                grant_o = (starve_cnt_p1 == CNT_W'(STARVE_MAX)) ? 2'b10 : 2'b01;
            end else if (elig0) begin
                grant_o = 2'b01;
            end else if (elig1) begin
                grant_o = 2'b10;
            end
        end
    end
`endif

    assign req0_ready_o = grant_o[0];
    assign req1_ready_o = grant_o[1];

    // Idle cycles park the ALU on ADD 0+0 to keep its inputs quiet.
    always_comb begin
        alu_operator_o  = ALU_ADD;
        alu_operand_a_o = '0;
        alu_operand_b_o = '0;
        if (grant_o[0]) begin
            alu_operator_o  = req0_operator_i;
            alu_operand_a_o = req0_operand_a_i;
            alu_operand_b_o = req0_operand_b_i;
        end else if (grant_o[1]) begin
            alu_operator_o  = req1_operator_i;
            alu_operand_a_o = req1_operand_a_i;
            alu_operand_b_o = req1_operand_b_i;
        end
    end

    // Response stage: a new grant wins over a simultaneous pop.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld0_p1 <= 1'b0;
            res0_p1 <= '0;
            cmp0_p1 <= 1'b0;
        end else if (grant_o[0]) begin
            vld0_p1 <= 1'b1;
            res0_p1 <= alu_result_i;
            cmp0_p1 <= alu_cmp_i;
        end else if (rsp0_ready_i) begin
            vld0_p1 <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld1_p1 <= 1'b0;
            res1_p1 <= '0;
            cmp1_p1 <= 1'b0;
        end else if (grant_o[1]) begin
            vld1_p1 <= 1'b1;
            res1_p1 <= alu_result_i;
            cmp1_p1 <= alu_cmp_i;
        end else if (rsp1_ready_i) begin
            vld1_p1 <= 1'b0;
        end
    end

    assign rsp0_valid_o  = vld0_p1;
    assign rsp0_result_o = res0_p1;
    assign rsp0_cmp_o    = cmp0_p1;
    assign rsp1_valid_o  = vld1_p1;
    assign rsp1_result_o = res1_p1;
    assign rsp1_cmp_o    = cmp1_p1;

endmodule

// File: tb/tb_zeroriscy_alu_arbiter.sv
// Directed bench for zeroriscy_alu_arbiter with a small behavioural ALU; honours ZERORISCY_ALU_ARB_RR_EN.
module tb_zeroriscy_alu_arbiter;

    localparam logic [5:0] OP_ADD = 6'b011000;
    localparam logic [5:0] OP_SUB = 6'b011001;
    localparam logic [5:0] OP_LTS = 6'b000000;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0_valid_i, req0_ready_o, req1_valid_i, req1_ready_o;
    logic [5:0]  req0_operator_i, req1_operator_i;
    logic [31:0] req0_operand_a_i, req0_operand_b_i, req1_operand_a_i, req1_operand_b_i;
    logic        rsp0_valid_o, rsp0_ready_i, rsp0_cmp_o;
    logic        rsp1_valid_o, rsp1_ready_i, rsp1_cmp_o;
    logic [31:0] rsp0_result_o, rsp1_result_o;
    logic [5:0]  alu_operator_o;
    logic [31:0] alu_operand_a_o, alu_operand_b_o, alu_result_i;
    logic        alu_cmp_i;
    logic [1:0]  grant_o;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    zeroriscy_alu_arbiter #(.STARVE_MAX(2), .CNT_W(4)) dut (
        .clk(clk), .rst(rst),
        .req0_valid_i(req0_valid_i), .req0_ready_o(req0_ready_o), .req0_operator_i(req0_operator_i),
        .req0_operand_a_i(req0_operand_a_i), .req0_operand_b_i(req0_operand_b_i),
        .req1_valid_i(req1_valid_i), .req1_ready_o(req1_ready_o), .req1_operator_i(req1_operator_i),
        .req1_operand_a_i(req1_operand_a_i), .req1_operand_b_i(req1_operand_b_i),
        .rsp0_valid_o(rsp0_valid_o), .rsp0_ready_i(rsp0_ready_i), .rsp0_result_o(rsp0_result_o),
        .rsp0_cmp_o(rsp0_cmp_o),
        .rsp1_valid_o(rsp1_valid_o), .rsp1_ready_i(rsp1_ready_i), .rsp1_result_o(rsp1_result_o),
        .rsp1_cmp_o(rsp1_cmp_o),
        .alu_operator_o(alu_operator_o), .alu_operand_a_o(alu_operand_a_o),
        .alu_operand_b_o(alu_operand_b_o), .alu_result_i(alu_result_i), .alu_cmp_i(alu_cmp_i),
        .grant_o(grant_o)
    );

    // Behavioural stand-in for the zero-riscy ALU.
    always_comb begin
        alu_result_i = alu_operand_a_o + alu_operand_b_o;
        alu_cmp_i    = (alu_operand_a_o == alu_operand_b_o);
        case (alu_operator_o)
            OP_SUB: alu_result_i = alu_operand_a_o - alu_operand_b_o;
            OP_LTS: begin
                alu_cmp_i    = ($signed(alu_operand_a_o) < $signed(alu_operand_b_o));
                alu_result_i = {31'b0, alu_cmp_i};
            end
            default: ;
        endcase
    end

    task automatic set_req0(input logic v, input logic [5:0] op, input logic [31:0] a, input logic [31:0] b);
        req0_valid_i = v; req0_operator_i = op; req0_operand_a_i = a; req0_operand_b_i = b;
    endtask

    task automatic set_req1(input logic v, input logic [5:0] op, input logic [31:0] a, input logic [31:0] b);
        req1_valid_i = v; req1_operator_i = op; req1_operand_a_i = a; req1_operand_b_i = b;
    endtask

    task automatic test_reset;
        @(negedge clk);
        rst = 1'b1;
        set_req0(1'b1, OP_ADD, 32'd1, 32'd1);
        set_req1(1'b0, OP_ADD, 32'd0, 32'd0);
        rsp0_ready_i = 1'b1; rsp1_ready_i = 1'b1;
        #1;
        n_tests++; if (grant_o !== 2'b00) begin n_fail++; $display("FAIL reset_grant: got %b want 00", grant_o); end
        n_tests++; if (req0_ready_o !== 1'b0) begin n_fail++; $display("FAIL reset_ready0: got %b want 0", req0_ready_o); end
        @(posedge clk); @(negedge clk);
        n_tests++; if (rsp0_valid_o !== 1'b0 || rsp1_valid_o !== 1'b0) begin
            n_fail++; $display("FAIL reset_valid: got %b%b want 00", rsp1_valid_o, rsp0_valid_o); end
        n_tests++; if (rsp0_result_o !== 32'd0 || rsp1_result_o !== 32'd0 || rsp0_cmp_o !== 1'b0 || rsp1_cmp_o !== 1'b0) begin
            n_fail++; $display("FAIL reset_data: got %h/%h want 0/0", rsp0_result_o, rsp1_result_o); end
        set_req0(1'b0, OP_ADD, 32'd0, 32'd0);
        rst = 1'b0;
    endtask

    task automatic test_single;
        @(negedge clk);
        set_req0(1'b1, OP_ADD, 32'd5, 32'd7);
        rsp0_ready_i = 1'b0;
        #1;
        n_tests++; if (grant_o !== 2'b01) begin n_fail++; $display("FAIL single_grant: got %b want 01", grant_o); end
        n_tests++; if (req0_ready_o !== 1'b1) begin n_fail++; $display("FAIL single_ready: got %b want 1", req0_ready_o); end
        n_tests++; if (alu_operand_a_o !== 32'd5 || alu_operand_b_o !== 32'd7) begin
            n_fail++; $display("FAIL single_alu_drive: got %0d,%0d want 5,7", alu_operand_a_o, alu_operand_b_o); end
        @(posedge clk); @(negedge clk);
        set_req0(1'b0, OP_SUB, 32'd9, 32'd9);
        #1;
        n_tests++; if (rsp0_valid_o !== 1'b1 || rsp0_result_o !== 32'd12) begin
            n_fail++; $display("FAIL single_rsp: got v=%b r=%0d want v=1 r=12", rsp0_valid_o, rsp0_result_o); end
        n_tests++; if (grant_o !== 2'b00 || alu_operator_o !== OP_ADD || alu_operand_a_o !== 32'd0) begin
            n_fail++; $display("FAIL idle_drive: got g=%b op=%b a=%h want 00/011000/0", grant_o, alu_operator_o, alu_operand_a_o); end
        @(posedge clk); @(negedge clk);
        n_tests++; if (rsp0_valid_o !== 1'b1 || rsp0_result_o !== 32'd12) begin
            n_fail++; $display("FAIL single_hold: got v=%b r=%0d want v=1 r=12", rsp0_valid_o, rsp0_result_o); end
        rsp0_ready_i = 1'b1;
        @(posedge clk); @(negedge clk);
        n_tests++; if (rsp0_valid_o !== 1'b0) begin n_fail++; $display("FAIL single_pop: got %b want 0", rsp0_valid_o); end
    endtask

    task automatic test_compare;
        @(negedge clk);
        set_req1(1'b1, OP_LTS, 32'hFFFF_FFFF, 32'd1);
        rsp1_ready_i = 1'b1;
        #1;
        n_tests++; if (grant_o !== 2'b10 || req1_ready_o !== 1'b1) begin
            n_fail++; $display("FAIL cmp_grant: got %b want 10", grant_o); end
        @(posedge clk); @(negedge clk);
        set_req1(1'b0, OP_ADD, 32'd0, 32'd0);
        n_tests++; if (rsp1_valid_o !== 1'b1 || rsp1_result_o !== 32'd1 || rsp1_cmp_o !== 1'b1) begin
            n_fail++; $display("FAIL cmp_rsp: got v=%b r=%0d c=%b want 1/1/1", rsp1_valid_o, rsp1_result_o, rsp1_cmp_o); end
    endtask

    task automatic test_starvation;
        logic [1:0] exp_seq [6];
`ifdef ZERORISCY_ALU_ARB_RR_EN
        exp_seq = '{2'b01, 2'b10, 2'b01, 2'b10, 2'b01, 2'b10};
`else
        exp_seq = '{2'b01, 2'b01, 2'b10, 2'b01, 2'b01, 2'b10};
`endif
        @(negedge clk);
        set_req0(1'b1, OP_ADD, 32'd1, 32'd1);
        set_req1(1'b1, OP_ADD, 32'd2, 32'd2);
        rsp0_ready_i = 1'b1; rsp1_ready_i = 1'b1;
        for (int i = 0; i < 6; i++) begin
            #1;
            n_tests++; if (grant_o !== exp_seq[i]) begin
                n_fail++; $display("FAIL starve_grant[%0d]: got %b want %b", i, grant_o, exp_seq[i]); end
            @(posedge clk); @(negedge clk);
            if (exp_seq[i] == 2'b10) begin
                n_tests++; if (rsp1_valid_o !== 1'b1 || rsp1_result_o !== 32'd4) begin
                    n_fail++; $display("FAIL starve_rsp1[%0d]: got v=%b r=%0d want 1/4", i, rsp1_valid_o, rsp1_result_o); end
            end else begin
                n_tests++; if (rsp0_valid_o !== 1'b1 || rsp0_result_o !== 32'd2) begin
                    n_fail++; $display("FAIL starve_rsp0[%0d]: got v=%b r=%0d want 1/2", i, rsp0_valid_o, rsp0_result_o); end
            end
        end
        set_req0(1'b0, OP_ADD, 32'd0, 32'd0);
        set_req1(1'b0, OP_ADD, 32'd0, 32'd0);
        @(posedge clk);
    endtask

    task automatic test_backpressure;
        @(negedge clk);
        set_req0(1'b1, OP_ADD, 32'd10, 32'd20);
        rsp0_ready_i = 1'b0;
        @(posedge clk); @(negedge clk);
        n_tests++; if (rsp0_valid_o !== 1'b1 || rsp0_result_o !== 32'd30) begin
            n_fail++; $display("FAIL bp_fill: got v=%b r=%0d want 1/30", rsp0_valid_o, rsp0_result_o); end
        set_req0(1'b1, OP_ADD, 32'd100, 32'd200);
        set_req1(1'b1, OP_ADD, 32'd3, 32'd4);
        rsp1_ready_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_tests++; if (grant_o !== 2'b10) begin n_fail++; $display("FAIL bp_grant[%0d]: got %b want 10", i, grant_o); end
            @(posedge clk); @(negedge clk);
            n_tests++; if (rsp0_result_o !== 32'd30 || rsp1_result_o !== 32'd7) begin
                n_fail++; $display("FAIL bp_data[%0d]: got %0d/%0d want 30/7", i, rsp0_result_o, rsp1_result_o); end
        end
        rsp0_ready_i = 1'b1;
        #1;
        n_tests++; if (grant_o !== 2'b01) begin n_fail++; $display("FAIL bp_release: got %b want 01", grant_o); end
        @(posedge clk); @(negedge clk);
        n_tests++; if (rsp0_valid_o !== 1'b1 || rsp0_result_o !== 32'd300) begin
            n_fail++; $display("FAIL bp_refill: got v=%b r=%0d want 1/300", rsp0_valid_o, rsp0_result_o); end
    endtask

    task automatic test_reset_mid;
        logic [1:0] exp_seq [4];
`ifdef ZERORISCY_ALU_ARB_RR_EN
        exp_seq = '{2'b01, 2'b10, 2'b01, 2'b10};
`else
        exp_seq = '{2'b01, 2'b01, 2'b10, 2'b01};
`endif
        rsp0_ready_i = 1'b0;
        rst = 1'b1;
        #1;
        n_tests++; if (grant_o !== 2'b00 || req0_ready_o !== 1'b0 || req1_ready_o !== 1'b0) begin
            n_fail++; $display("FAIL midrst_grant: got %b rdy=%b%b want 00", grant_o, req1_ready_o, req0_ready_o); end
        @(posedge clk); @(negedge clk);
        n_tests++; if (rsp0_valid_o !== 1'b0 || rsp1_valid_o !== 1'b0 || rsp0_result_o !== 32'd0) begin
            n_fail++; $display("FAIL midrst_rsp: got v=%b%b r=%0d want 00/0", rsp1_valid_o, rsp0_valid_o, rsp0_result_o); end
        rst = 1'b0;
        rsp0_ready_i = 1'b1; rsp1_ready_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            n_tests++; if (grant_o !== exp_seq[i]) begin
                n_fail++; $display("FAIL postrst_grant[%0d]: got %b want %b", i, grant_o, exp_seq[i]); end
            @(posedge clk); @(negedge clk);
        end
    endtask

    initial begin
        rst = 1'b1;
        set_req0(1'b0, OP_ADD, 32'd0, 32'd0);
        set_req1(1'b0, OP_ADD, 32'd0, 32'd0);
        rsp0_ready_i = 1'b0; rsp1_ready_i = 1'b0;
        test_reset();
        test_single();
        test_compare();
        test_starvation();
        test_backpressure();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/zeroriscy_alu_arbiter.md
Name: zeroriscy_alu_arbiter

Overview:
- Shares the single combinational zero-riscy ALU between two requesters.
  - Port 0: core pipeline, the primary requester.
  - Port 1: auxiliary requester, e.g. the debug unit or a coprocessor.
- Each port uses a valid/ready request channel and a 1-entry registered response buffer.
- Default policy is fixed priority to port 0, with a starvation counter that forces a port-1 grant.
- The block drives the ALU operator/operand inputs and captures result_o and comparison_result_o.

Parameters:
- STARVE_MAX, 4: consecutive port-0 grants tolerated while port 1 is eligible; legal range 1..15.
- CNT_W, 4: starvation counter width; must satisfy 2^CNT_W > STARVE_MAX.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- req0_valid_i / req1_valid_i  in  1  request valid, per port
- req0_ready_o / req1_ready_o  out  1  request accepted this cycle, per port
- req0_operator_i / req1_operator_i  in  ALU_OP_WIDTH  ALU operator, per port
- req0_operand_a_i / req1_operand_a_i  in  32  operand a, per port
- req0_operand_b_i / req1_operand_b_i  in  32  operand b, per port
- rsp0_valid_o / rsp1_valid_o  out  1  response buffer full, per port
- rsp0_ready_i / rsp1_ready_i  in  1  consumer takes the response, per port
- rsp0_result_o / rsp1_result_o  out  32  captured ALU result_o
- rsp0_cmp_o / rsp1_cmp_o  out  1  captured comparison_result_o
- alu_operator_o  out  ALU_OP_WIDTH  to ALU operator_i
- alu_operand_a_o  out  32  to ALU operand_a_i
- alu_operand_b_o  out  32  to ALU operand_b_i
- alu_result_i  in  32  from ALU result_o
- alu_cmp_i  in  1  from ALU comparison_result_o
- grant_o  out  2  one-hot grant this cycle; 00 when idle

Behaviour:
- Clocking: single clock clk; rst is synchronous, active-high.
- Reset values: rsp*_valid_o=0, rsp*_result_o=0, rsp*_cmp_o=0, starvation counter=0. All request-side outputs are combinational.
- Eligibility: port n is eligible when reqn_valid_i && (!rspn_valid_o || rspn_ready_i). A buffer drained in a cycle may be refilled in the same cycle.
- Grant (combinational, default policy):
  - Only port 0 eligible -> grant port 0; only port 1 eligible -> grant port 1.
  - Both eligible and counter < STARVE_MAX -> grant port 0.
  - Both eligible and counter == STARVE_MAX -> grant port 1.
- reqn_ready_o = grant_o[n]. At most one grant per cycle.
- ALU drive:
  - With a grant: the granted port's operator/operands pass straight through.
  - Idle: operator = ALU_ADD, operands = 0, to limit toggling.
- Latency: request accepted in cycle N -> rspn_valid_o=1 with result from cycle N+1.
- Response capture:
  - On a grant, the rising edge loads rspn_result_o <= alu_result_i and rspn_cmp_o <= alu_cmp_i, and sets rspn_valid_o.
  - Otherwise rspn_ready_i && rspn_valid_o clears rspn_valid_o.
  - Data holds while valid && !ready.
- Starvation counter:
  - Increments when port 0 is granted while port 1 is eligible; saturates at STARVE_MAX.
  - Clears to 0 when port 1 is granted, or when port 1 is not eligible.
- Backpressure: a port with a full buffer and rspn_ready_i=0 is never granted. The other port may still use the ALU.
- Request stability: the requester holds operator/operands stable while valid && !ready. The arbiter does not register them.
- Reset mid-operation: buffered responses are discarded; no grant is issued in the reset cycle (grant_o=00, ready=0).
- Simultaneous events on one port in the same cycle (grant + rsp pop): the new result wins and valid stays 1.

Optional Feature:
- Macro: ZERORISCY_ALU_ARB_RR_EN.
- Defined: round-robin arbitration.
  - A 1-bit last-grant register (reset 1) selects the port not granted last when both are eligible.
  - The register updates on every grant.
  - The starvation counter and STARVE_MAX are unused; no counter flops are synthesised.
- Undefined: fixed priority with starvation counter, as specified above.

Test Plan:
- Single request: port 0 ALU_ADD a=5, b=7 -> req0_ready_o=1 same cycle, grant_o=01; next cycle rsp0_valid_o=1, rsp0_result_o=12.
- Comparison: port 1 ALU_LTS a=0xFFFFFFFF, b=1 with port 0 idle -> rsp1_result_o=1, rsp1_cmp_o=1 one cycle later.
- Starvation (STARVE_MAX=2, both valid continuously, both rsp_ready=1) -> grant sequence 0,0,1,0,0,1; counter returns to 0 after each port-1 grant.
- Backpressure: rsp0 full with rsp0_ready_i=0, both requests valid -> port 1 granted every cycle, rsp0_result_o unchanged. Raise rsp0_ready_i -> port 0 granted that same cycle.
- Reset mid-operation: assert rst with rsp0_valid_o=1 and both requests valid -> next edge: rsp*_valid_o=0, counter=0; grant_o=00 during the reset cycle.
- RR build (ZERORISCY_ALU_ARB_RR_EN), both valid continuously -> grant sequence 0,1,0,1 starting with port 0 after reset.
